// File: rtl/seed_pkg.sv
// Shared constants and types for the SEED output-side blocks.
package seed_pkg;

  localparam int SEED_BLK_W  = 128;
  localparam int SEED_BYTE_W = 8;
  localparam int SEED_BYTES  = 16;
  localparam int SEED_CNT_W  = $clog2(SEED_BYTES);

  // Collector FSM: waiting for the first byte, or mid-block.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } col_state_e;

endpackage

// File: rtl/seed_blk_fifo.sv
// DEPTH x W synchronous circular FIFO. Head word is presented directly from
// storage. A push while full is taken only when a pop happens in the same
// cycle; otherwise it is ignored and the caller accounts for the drop.
module seed_blk_fifo
  import seed_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = SEED_BLK_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: unchanged on simultaneous push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seed_block_collector.sv
// Collects the byte-serial SEED ciphertext into 128-bit blocks and queues
// them for the host on a valid/ready interface. The core cannot be stalled,
// so full-FIFO drops raise a sticky overflow and short bursts a frame_err
// pulse. Optional: define SEED_COLLECT_STATS_EN for blk_cnt/drop_cnt.
module seed_block_collector
  import seed_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [SEED_BYTE_W-1:0] cryp_in,
  input  logic                   cryp_valid,
  output logic [SEED_BLK_W-1:0]  blk_out,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  input  logic                   err_clr,
  output logic                   overflow,
`ifdef SEED_COLLECT_STATS_EN
  output logic [15:0]            blk_cnt,
  output logic [15:0]            drop_cnt,
`endif
  output logic                   frame_err
);

  localparam int BYTES = SEED_BYTES;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [SEED_CNT_W-1:0] LAST    = SEED_CNT_W'(BYTES - 1);
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);

  col_state_e            state;
  logic [SEED_CNT_W-1:0] byte_cnt;
  // Only the first 15 bytes need storage; the 16th is merged on commit.
  logic [SEED_BLK_W-SEED_BYTE_W-1:0] asm_q;

  logic                  commit, pop, push_ok, drop, frame_det;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [SEED_BLK_W-1:0] blk_data;

  assign commit    = (state == COLLECT) && cryp_valid && (byte_cnt == LAST);
  assign frame_det = (state == COLLECT) && !cryp_valid;
  assign blk_data  = {asm_q, cryp_in};
  assign pop       = blk_valid && blk_ready;
  assign push_ok   = commit && ((fifo_count < DEPTH_C) || pop);
  assign drop      = commit && fifo_full && !pop;
  assign blk_valid = !fifo_empty;

  // Assembly FSM: shift bytes in, commit on the 16th, abort on a gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      asm_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cryp_valid) begin
            asm_q    <= {asm_q[SEED_BLK_W-2*SEED_BYTE_W-1:0], cryp_in};
            byte_cnt <= SEED_CNT_W'(1);
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (!cryp_valid) begin
            byte_cnt  <= '0;
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (byte_cnt == LAST) begin
            byte_cnt <= '0;
            state    <= IDLE;
          end else begin
            asm_q    <= {asm_q[SEED_BLK_W-2*SEED_BYTE_W-1:0], cryp_in};
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (err_clr) overflow <= 1'b0;
  end

`ifdef SEED_COLLECT_STATS_EN
  // Saturating statistics; err_clr restarts the drop count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok && blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 1'b1;
      if (drop || frame_det) begin
        if (err_clr)                  drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end else if (err_clr) begin
        drop_cnt <= '0;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = frame_det;
`endif

  seed_blk_fifo #(.DEPTH(DEPTH), .W(SEED_BLK_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_ok),
    .wr_data (blk_data),
    .pop     (pop),
    .rd_data (blk_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_seed_block_collector.sv
// Scoreboarded bench for seed_block_collector (DEPTH=2).
module tb_seed_block_collector;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   cryp_in;
  logic         cryp_valid;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic         blk_ready;
  logic         err_clr;
  logic         overflow;
  logic         frame_err;
`ifdef SEED_COLLECT_STATS_EN
  logic [15:0]  blk_cnt;
  logic [15:0]  drop_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  logic [127:0] expq[$];

  always #5 clk = ~clk;

  seed_block_collector #(.DEPTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cryp_in    (cryp_in),
    .cryp_valid (cryp_valid),
    .blk_out    (blk_out),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .err_clr    (err_clr),
    .overflow   (overflow),
`ifdef SEED_COLLECT_STATS_EN
    .blk_cnt    (blk_cnt),
    .drop_cnt   (drop_cnt),
`endif
    .frame_err  (frame_err)
  );

  // Scoreboard: every handshake must match the oldest expected block.
  always @(negedge clk) begin
    if (reset_n && frame_err) fe_cnt++;
    if (reset_n && blk_valid && blk_ready) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected got=%h expected=none", blk_out);
      end else begin
        logic [127:0] e;
        e = expq.pop_front();
        if (blk_out !== e) begin
          fails++;
          $display("FAIL pop_data got=%h expected=%h", blk_out, e);
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cryp_valid = 1'b1;
    cryp_in    = b;
    step();
  endtask

  task automatic idle(input int n);
    cryp_valid = 1'b0;
    repeat (n) step();
  endtask

  // 16 consecutive bytes base, base+1, ...; expected block queued if kept.
  task automatic send_block(input logic [7:0] base, input bit keep);
    logic [127:0] e;
    e = '0;
    for (int i = 0; i < 16; i++) e = {e[119:0], 8'(base + 8'(i))};
    if (keep) expq.push_back(e);
    for (int i = 0; i < 16; i++) send_byte(8'(base + 8'(i)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    blk_ready = 1'b1;
    while ((expq.size() != 0 || blk_valid) && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (expq.size() != 0 || blk_valid) begin
      fails++;
      $display("FAIL drain left=%0d blk_valid=%b expected=0/0", expq.size(), blk_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cryp_valid = 1'b0; cryp_in = '0;
    blk_ready = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    tests++;
    if ({blk_valid, overflow, frame_err} !== 3'b000 || blk_out !== '0) begin
      fails++;
      $display("FAIL reset_state v/o/f=%b%b%b out=%h expected 000/0",
               blk_valid, overflow, frame_err, blk_out);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    blk_ready = 1'b1;
    send_block(8'h00, 1'b1);
    cryp_valid = 1'b0;
    tests++;
    if (blk_valid !== 1'b1 || blk_out !== 128'h000102030405060708090A0B0C0D0E0F) begin
      fails++;
      $display("FAIL basic_latency v=%b out=%h expected 1/000102..0F", blk_valid, blk_out);
    end
    step();
    tests++;
    if (blk_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL basic_popped v=%b ovf=%b expected 0/0", blk_valid, overflow);
    end
    drain();
  endtask

  task automatic test_split();
    logic [127:0] e;
    int f0;
    f0 = fe_cnt;
    e = '0;
    for (int i = 0; i < 16; i++) e = {e[119:0], 8'(8'h20 + 8'(i))};
    expq.push_back(e);
    for (int i = 0; i < 9; i++)  send_byte(8'(8'h20 + 8'(i)));
    for (int i = 9; i < 16; i++) send_byte(8'(8'h20 + 8'(i)));
    idle(2);
    drain();
    tests++;
    if (fe_cnt != f0) begin
      fails++;
      $display("FAIL split_frame_err got=%0d expected=0", fe_cnt - f0);
    end
  endtask

  task automatic test_overflow();
    blk_ready = 1'b0;
    send_block(8'hA0, 1'b1);
    send_block(8'hB0, 1'b1);
    send_block(8'hC0, 1'b0);
    cryp_valid = 1'b0;
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set got=%b expected=1", overflow);
    end
    tests++;
    if (blk_valid !== 1'b1 || blk_out !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF) begin
      fails++;
      $display("FAIL ovf_head v=%b out=%h expected 1/A0..AF", blk_valid, blk_out);
    end
`ifdef SEED_COLLECT_STATS_EN
    tests++;
    if (drop_cnt !== 16'd1) begin
      fails++;
      $display("FAIL ovf_drop_cnt got=%0d expected=1", drop_cnt);
    end
`endif
    step();
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky got=%b expected=1", overflow);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear got=%b expected=0", overflow);
    end
  endtask

  // FIFO still full (A,B): 16th byte of D coincides with a pop.
  task automatic test_full_pop();
    logic [127:0] e;
    e = '0;
    for (int i = 0; i < 16; i++) e = {e[119:0], 8'(8'hD0 + 8'(i))};
    expq.push_back(e);
    for (int i = 0; i < 15; i++) send_byte(8'(8'hD0 + 8'(i)));
    blk_ready = 1'b1;
    send_byte(8'hDF);
    blk_ready = 1'b0;
    cryp_valid = 1'b0;
    tests++;
    if (overflow !== 1'b0 || blk_valid !== 1'b1) begin
      fails++;
      $display("FAIL fullpop ovf=%b v=%b expected 0/1", overflow, blk_valid);
    end
    step();
    drain();
  endtask

  task automatic test_frame();
    int f0;
    f0 = fe_cnt;
    blk_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + 8'(i)));
    idle(1);
    send_block(8'h10, 1'b1);
    idle(2);
    drain();
    tests++;
    if (fe_cnt - f0 != 1) begin
      fails++;
      $display("FAIL frame_pulses got=%0d expected=1", fe_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    blk_ready = 1'b1;
    send_block(8'h70, 1'b1);
    send_block(8'h80, 1'b1);
    idle(1);
    drain();
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = fe_cnt;
    blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h90 + 8'(i)));
    cryp_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    tests++;
    if ({blk_valid, overflow, frame_err} !== 3'b000 || blk_out !== '0) begin
      fails++;
      $display("FAIL midreset v/o/f=%b%b%b out=%h expected 000/0",
               blk_valid, overflow, frame_err, blk_out);
    end
    step();
    reset_n = 1'b1;
    step();
    send_block(8'h60, 1'b1);
    cryp_valid = 1'b0;
    tests++;
    if (blk_valid !== 1'b1 || blk_out !== 128'h606162636465666768696A6B6C6D6E6F) begin
      fails++;
      $display("FAIL midreset_block v=%b out=%h expected 1/60..6F", blk_valid, blk_out);
    end
    drain();
    tests++;
    if (fe_cnt != f0) begin
      fails++;
      $display("FAIL midreset_frame got=%0d expected=0", fe_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_overflow();
    test_full_pop();
    test_frame();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
